data_memory_arbiter: RTL and testbench

Sequencing arbiter that shares the single-port DFFRAM data memory between the RISC-V core load/store unit and the interface memory controller (SPI loader). It takes the place of static select-line muxing: it accepts one request per access, arbitrates, generates byte-lane write enables from size and address, drives the RAM for one cycle, and returns lane-extracted, zero-extended read data with a valid pulse.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_lane_align.sv | 38 +++
 rtl/data_memory_arbiter.sv | 139 +++++++++++++
 tb/tb_data_memory_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data memory arbiter.
// Provides access size codes, FSM state type, requester ids and the alignment rule.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic ID_CORE = 1'b0;
   localparam logic ID_INTF = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Size code 2'b11 behaves like a word access.
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] off);
      logic m;
      m = 1'b0;
      unique case (size)
         SZ_BYTE: m = 1'b0;
         SZ_HALF: m = off[0];
         default: m = (off != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane write enables, write data replication and read lane extraction.
// Ports: size/off (access size, byte offset), wdata/rword in; we, di, rdata (zero-extended) out.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  we,
   output logic [31:0] di,
   output logic [31:0] rdata
);

   always_comb begin
      we    = 4'b1111;
      di    = wdata;
      rdata = rword;
      unique case (size)
         SZ_BYTE: begin
            we    = 4'b0001 << off;
            di    = {4{wdata[7:0]}};
            rdata = (rword >> {off, 3'b000}) & 32'h0000_00ff;
         end
         SZ_HALF: begin
            we    = 4'b0011 << {off[1], 1'b0};
            di    = {2{wdata[15:0]}};
            rdata = (rword >> {off[1], 4'b0000}) & 32'h0000_ffff;
         end
         SZ_WORD, 2'b11: begin
            we    = 4'b1111;
            di    = wdata;
            rdata = rword;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-port data RAM between core LSU and interface loader.
// Ports: core_*/intf_* request/grant/err/rvalid/rdata, ram_en/we/a/di/do; macro DMEM_ARB_RR_EN = round-robin.
module data_memory_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_LENGTH    = 32,
   parameter int ADDRESS_LENGTH = 13
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      core_req,
   input  logic                      core_wr,
   input  logic [ADDRESS_LENGTH-1:0] core_addr,
   input  logic [DATA_LENGTH-1:0]    core_wdata,
   input  logic [1:0]                core_size,
   output logic                      core_gnt,
   output logic                      core_err,
   output logic                      core_rvalid,
   output logic [DATA_LENGTH-1:0]    core_rdata,
   input  logic                      intf_req,
   input  logic                      intf_wr,
   input  logic [ADDRESS_LENGTH-1:0] intf_addr,
   input  logic [DATA_LENGTH-1:0]    intf_wdata,
   input  logic [1:0]                intf_size,
   output logic                      intf_gnt,
   output logic                      intf_err,
   output logic                      intf_rvalid,
   output logic [DATA_LENGTH-1:0]    intf_rdata,
   output logic                      ram_en,
   output logic [3:0]                ram_we,
   output logic [ADDRESS_LENGTH-3:0] ram_a,
   output logic [DATA_LENGTH-1:0]    ram_di,
   input  logic [DATA_LENGTH-1:0]    ram_do
);

   state_e state, state_nx;

   logic                      id_q, wr_q, err_q, last_q;
   logic [ADDRESS_LENGTH-1:0] addr_q;
   logic [DATA_LENGTH-1:0]    wdata_q;
   logic [1:0]                size_q;

   logic                      any_req, pick_intf, access;
   logic                      sel_wr;
   logic [ADDRESS_LENGTH-1:0] sel_addr;
   logic [DATA_LENGTH-1:0]    sel_wdata;
   logic [1:0]                sel_size;

   logic [3:0]                lane_we;
   logic [DATA_LENGTH-1:0]    lane_di, lane_rd;

   assign any_req = core_req | intf_req;

`ifdef DMEM_ARB_RR_EN
   // On contention the side not granted last goes first.
   assign pick_intf = intf_req & (~core_req | (last_q == ID_CORE));
`else
   assign pick_intf = intf_req & ~core_req;
`endif

   assign sel_wr    = pick_intf ? intf_wr    : core_wr;
   assign sel_addr  = pick_intf ? intf_addr  : core_addr;
   assign sel_wdata = pick_intf ? intf_wdata : core_wdata;
   assign sel_size  = pick_intf ? intf_size  : core_size;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (any_req) state_nx = ST_ACCESS;
         ST_ACCESS: state_nx = (wr_q || err_q) ? ST_IDLE : ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q        <= ID_CORE;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         last_q      <= ID_INTF;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= SZ_BYTE;
         core_rvalid <= 1'b0;
         intf_rvalid <= 1'b0;
         core_rdata  <= '0;
         intf_rdata  <= '0;
      end else begin
         core_rvalid <= 1'b0;
         intf_rvalid <= 1'b0;
         if (state == ST_IDLE && any_req) begin
            id_q    <= pick_intf ? ID_INTF : ID_CORE;
            last_q  <= pick_intf ? ID_INTF : ID_CORE;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            size_q  <= sel_size;
            err_q   <= misaligned(sel_size, sel_addr[1:0]);
         end
         if (state == ST_RESP) begin
            if (id_q == ID_CORE) begin
               core_rdata  <= lane_rd;
               core_rvalid <= 1'b1;
            end else begin
               intf_rdata  <= lane_rd;
               intf_rvalid <= 1'b1;
            end
         end
      end
   end

   dmem_lane_align u_lane (
      .size  (size_q),
      .off   (addr_q[1:0]),
      .wdata (wdata_q),
      .rword (ram_do),
      .we    (lane_we),
      .di    (lane_di),
      .rdata (lane_rd)
   );

   // Strobes derive from state so an async reset drops them at once.
   assign access   = (state == ST_ACCESS);
   assign ram_en   = access & ~err_q;
   assign ram_we   = (ram_en & wr_q) ? lane_we : 4'b0000;
   assign ram_a    = addr_q[ADDRESS_LENGTH-1:2];
   assign ram_di   = lane_di;
   assign core_gnt = access & (id_q == ID_CORE);
   assign intf_gnt = access & (id_q == ID_INTF);
   assign core_err = core_gnt & err_q;
   assign intf_err = intf_gnt & err_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: randomized and directed checks of data_memory_arbiter.
// Uses a byte-array reference memory and a synchronous RAM model; DMEM_ARB_RR_EN selects arbitration.
module tb_data_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_v   [2];
   logic        wr_v    [2];
   logic [12:0] addr_v  [2];
   logic [31:0] wdata_v [2];
   logic [1:0]  size_v  [2];

   logic        core_gnt, core_err, core_rvalid;
   logic        intf_gnt, intf_err, intf_rvalid;
   logic [31:0] core_rdata, intf_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [10:0] ram_a;
   logic [31:0] ram_di, ram_do;

   logic [31:0] ram  [0:2047];
   logic [7:0]  refm [0:127];
   logic [31:0] exp_rdata [2];
   int          last_gnt;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   data_memory_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req    (req_v[0]),
      .core_wr     (wr_v[0]),
      .core_addr   (addr_v[0]),
      .core_wdata  (wdata_v[0]),
      .core_size   (size_v[0]),
      .core_gnt    (core_gnt),
      .core_err    (core_err),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .intf_req    (req_v[1]),
      .intf_wr     (wr_v[1]),
      .intf_addr   (addr_v[1]),
      .intf_wdata  (wdata_v[1]),
      .intf_size   (size_v[1]),
      .intf_gnt    (intf_gnt),
      .intf_err    (intf_err),
      .intf_rvalid (intf_rvalid),
      .intf_rdata  (intf_rdata),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_a       (ram_a),
      .ram_di      (ram_di),
      .ram_do      (ram_do)
   );

   always @(posedge clk) begin
      if (ram_en) begin
         for (int k = 0; k < 4; k++)
            if (ram_we[k]) ram[ram_a][8*k +: 8] <= ram_di[8*k +: 8];
         ram_do <= ram[ram_a];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic gnt_of(input int id);
      return (id == 0) ? core_gnt : intf_gnt;
   endfunction
   function automatic logic err_of(input int id);
      return (id == 0) ? core_err : intf_err;
   endfunction
   function automatic logic rvalid_of(input int id);
      return (id == 0) ? core_rvalid : intf_rvalid;
   endfunction
   function automatic logic [31:0] rdata_of(input int id);
      return (id == 0) ? core_rdata : intf_rdata;
   endfunction

   function automatic int exp_winner();
`ifdef DMEM_ARB_RR_EN
      return (last_gnt == 0) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic set_req(input int id, input logic wr, input logic [12:0] a,
                          input logic [31:0] d, input logic [1:0] sz);
      wr_v[id]    = wr;
      addr_v[id]  = a;
      wdata_v[id] = d;
      size_v[id]  = sz;
      req_v[id]   = 1'b1;
   endtask

   // Called right after a gnt is seen; leaves the bench one or two edges later.
   task automatic do_access(input int id);
      int          nb, base, off;
      logic        mis;
      logic [3:0]  ewe;
      logic [31:0] edi, erd;
      nb   = (size_v[id] == 2'd0) ? 1 : (size_v[id] == 2'd1) ? 2 : 4;
      base = (int'(addr_v[id]) / nb) * nb;
      off  = base % 4;
      mis  = (base != int'(addr_v[id]));
      chk("err", err_of(id), mis);
      chk("ram_en", ram_en, !mis);
      if (!mis) begin
         chk("ram_a", ram_a, addr_v[id] >> 2);
         ewe = '0;
         edi = '0;
         if (wr_v[id]) begin
            for (int i = 0; i < nb; i++) begin
               ewe[off+i] = 1'b1;
               refm[(base+i)%128] = wdata_v[id][8*i +: 8];
            end
            for (int k = 0; k < 4; k++)
               edi[8*k +: 8] = wdata_v[id][8*(k%nb) +: 8];
            chk("ram_we", ram_we, ewe);
            chk("ram_di", ram_di, edi);
         end else begin
            chk("ram_we_rd", ram_we, 0);
         end
      end
      @(posedge clk); #1;
      chk("rvalid_early", rvalid_of(id), 0);
      if (!mis && !wr_v[id]) begin
         erd = '0;
         for (int i = 0; i < nb; i++)
            erd[8*i +: 8] = refm[(base+i)%128];
         @(posedge clk); #1;
         chk("rvalid", rvalid_of(id), 1);
         chk("rdata", rdata_of(id), erd);
         exp_rdata[id] = erd;
         chk("rdata_other", rdata_of(1-id), exp_rdata[1-id]);
      end
   endtask

   task automatic run_round();
      int   served, want, cyc;
      logic both, first;
      served = 0;
      cyc    = 0;
      want   = int'(req_v[0]) + int'(req_v[1]);
      both   = req_v[0] & req_v[1];
      first  = 1'b1;
      while (served < want && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (core_gnt || intf_gnt) begin
            int id;
            id = intf_gnt ? 1 : 0;
            chk("gnt_onehot", core_gnt & intf_gnt, 0);
            chk("gnt_pending", req_v[id], 1);
            if (first && both) chk("arb_winner", id, exp_winner());
            first     = 1'b0;
            last_gnt  = id;
            served++;
            req_v[id] = 1'b0;
            do_access(id);
         end
      end
      if (served < want) chk("gnt_timeout", served, want);
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_core_gnt", core_gnt, 0);
      chk("rst_intf_gnt", intf_gnt, 0);
      chk("rst_core_err", core_err, 0);
      chk("rst_intf_err", intf_err, 0);
      chk("rst_core_rvalid", core_rvalid, 0);
      chk("rst_intf_rvalid", intf_rvalid, 0);
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_intf_rdata", intf_rdata, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_a", ram_a, 0);
      chk("rst_ram_di", ram_di, 0);
   endtask

   initial begin
      logic [31:0] v;
      int          n, cyc;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; wr_v[i] = 1'b0; addr_v[i] = '0;
         wdata_v[i] = '0; size_v[i] = '0; exp_rdata[i] = '0;
      end
      last_gnt = 1;
      for (int w = 0; w < 32; w++) begin
         v = $urandom;
         ram[w] <= v;
         for (int b = 0; b < 4; b++) refm[4*w+b] = v[8*b +: 8];
      end
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      // Contention: both held for four grants.
      set_req(0, 1'b1, 13'h020, 32'hC0C0_0001, 2'd2);
      set_req(1, 1'b1, 13'h024, 32'h1F1F_0002, 2'd2);
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (core_gnt || intf_gnt) begin
            int id;
            id = intf_gnt ? 1 : 0;
            chk("cont_winner", id, exp_winner());
            last_gnt = id;
            n++;
            do_access(id);
         end
      end
      if (n < 4) chk("cont_timeout", n, 4);
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Directed cases.
      set_req(0, 1'b1, 13'h010, 32'hDEAD_BEEF, 2'd2); run_round();
      set_req(0, 1'b0, 13'h010, 32'h0, 2'd2);         run_round();
      set_req(1, 1'b1, 13'h013, 32'h0000_00A5, 2'd0); run_round();
      set_req(1, 1'b0, 13'h010, 32'h0, 2'd2);         run_round();
      chk("byte_merge", intf_rdata, 32'hA5AD_BEEF);
      set_req(0, 1'b1, 13'h010, 32'h1234_ABCD, 2'd2); run_round();
      set_req(0, 1'b0, 13'h012, 32'h0, 2'd1);         run_round();
      chk("half_hi", core_rdata, 32'h0000_1234);
      set_req(0, 1'b0, 13'h011, 32'h0, 2'd1);         run_round();
      chk("misalign_keep", core_rdata, 32'h0000_1234);

      // Reset in the middle of a write access.
      set_req(0, 1'b1, 13'h018, 32'h1122_3344, 2'd2);
      cyc = 0;
      while (!core_gnt && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("mid_gnt", core_gnt, 1);
      rst_n = 1'b0;
      req_v[0] = 1'b0;
      #1;
      check_reset_outputs();
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      last_gnt = 1;
      @(posedge clk); #1;
      chk("mid_hold_en", ram_en, 0);
      rst_n = 1'b1;
      set_req(0, 1'b0, 13'h018, 32'h0, 2'd2); run_round();

      // Randomized traffic.
      for (int r = 0; r < 80; r++) begin
         for (int id = 0; id < 2; id++)
            if ($urandom_range(0, 9) < 7)
               set_req(id, 1'($urandom), 13'($urandom_range(0, 127)),
                       $urandom, 2'($urandom));
         if (!req_v[0] && !req_v[1])
            set_req(0, 1'b0, 13'($urandom_range(0, 127)), 32'h0, 2'd0);
         run_round();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
